// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional bounds checking is enabled with the DMEM_BOUNDS_CHECK_EN macro (see dmem_responder).
package dmem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic ACC_WORD = 1'b0;
    localparam logic ACC_BYTE = 1'b1;

    localparam int unsigned BYTE_W = 8;

    // Bit offset of a byte lane inside a little-endian 32-bit word.
    function automatic logic [4:0] lane_shift(input logic [1:0] lane);
        return {lane, 3'b000};
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane datapath: merges store data into an existing word and extracts
// sign-extended bytes (lb semantics) or whole words for loads.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic        worb,
    output logic [31:0] merged,
    input  logic [31:0] rd_word,
    output logic [31:0] rdata
);

    logic [7:0] sel_byte;

    always_comb begin
        merged = old_word;
        if (worb == ACC_BYTE) begin
            merged[lane_shift(lane) +: BYTE_W] = wdata[7:0];
        end else begin
            merged = wdata;
        end
    end

    always_comb begin
        sel_byte = rd_word[lane_shift(lane) +: BYTE_W];
        if (worb == ACC_BYTE) begin
            rdata = {{24{sel_byte[7]}}, sel_byte};
        end else begin
            rdata = rd_word;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data memory for the MIPS memory stage: combinational loads, edge-committed stores,
// zero-clear on reset. Define DMEM_BOUNDS_CHECK_EN to add err/err_addr bounds checking.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    input  logic        worb,
    output logic [31:0] readdata,
    output logic        ready
`ifdef DMEM_BOUNDS_CHECK_EN
   ,output logic        err,
    output logic [31:0] err_addr
`endif
);

    logic [31:0]   mem_q [DEPTH];
    state_e        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          ready_q, ready_d;

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   cur_word, merged, rd_ext;
    logic          acc_bad;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;

    assign idx      = addr[AW+1:2];
    assign lane     = addr[1:0];
    assign cur_word = mem_q[idx];

    dmem_lane_unit u_lane (
        .old_word (cur_word),
        .wdata    (writedata),
        .lane     (lane),
        .worb     (worb),
        .merged   (merged),
        .rd_word  (cur_word),
        .rdata    (rd_ext)
    );

`ifdef DMEM_BOUNDS_CHECK_EN
    logic          err_q, err_d;
    logic [31:0]   err_addr_q, err_addr_d;

    assign acc_bad = (state_q == RUN) &&
                     (((addr[31:AW+2] != '0) && memwrite) ||
                      ((worb == ACC_WORD) && (lane != 2'b00)));

    // Only the first offending address is kept; err stays set until reset.
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (acc_bad && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];
    assign acc_bad        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        wr_en     = 1'b0;
        wr_idx    = idx;
        wr_data   = merged;
        case (state_q)
            INIT: begin
                wr_en     = 1'b1;
                wr_idx    = clr_cnt_q;
                wr_data   = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                wr_en = memwrite && !acc_bad && !reset;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign readdata = ((state_q == RUN) && !acc_bad) ? rd_ext : '0;
    assign ready    = ready_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes model predictions, a negedge
// monitor pops and compares. Covers err/err_addr too when DMEM_BOUNDS_CHECK_EN is defined.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] writedata = '0;
    logic        worb = 1'b0;
    logic [31:0] readdata;
    logic        ready;
`ifdef DMEM_BOUNDS_CHECK_EN
    logic        err;
    logic [31:0] err_addr;
`endif

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .worb      (worb),
        .readdata  (readdata),
        .ready     (ready)
`ifdef DMEM_BOUNDS_CHECK_EN
       ,.err       (err),
        .err_addr  (err_addr)
`endif
    );

    typedef struct {
        bit          chk;
        logic [31:0] rd;
        bit          rdy;
        bit          err;
        logic [31:0] eaddr;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference model: plain word array plus a countdown of init cycles remaining.
    logic [31:0] m_mem [DEPTH];
    int unsigned m_init_left = DEPTH;
    bit          m_known = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_eaddr = '0;

    function automatic bit is_bad_access(input logic [31:0] a, input bit we, input bit wb);
`ifdef DMEM_BOUNDS_CHECK_EN
        return ((((a >> (AW + 2)) != 0) && we) || (!wb && ((a % 4) != 0)));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input bit wb);
        int unsigned w, ln, b;
        w  = m_mem[(a / 4) % DEPTH];
        ln = a % 4;
        if (!wb) return w;
        b = (w >> (ln * 8)) % 256;
        return (b >= 128) ? (32'hFFFF_FF00 + b) : b;
    endfunction

    task automatic cyc(input bit rst, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input bit wb, input string nm,
                       input bit use_c, input logic [31:0] cval);
        exp_t        e;
        bit          running, bad;
        int unsigned ix, ln;
        logic [31:0] msk;
        @(posedge clk);
        #1;
        reset = rst; memwrite = we; addr = a; writedata = wd; worb = wb;
        running = (m_init_left == 0);
        bad     = running && is_bad_access(a, we, wb);
        e.chk   = m_known;
        e.rdy   = running;
        e.rd    = (!running || bad) ? 32'h0 : model_read(a, wb);
        if (use_c) e.rd = cval;
        e.err   = m_err;
        e.eaddr = m_eaddr;
        e.name  = nm;
        exp_q.push_back(e);
        if (rst) begin
            m_known     = 1'b1;
            m_init_left = DEPTH;
            for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
            m_err   = 1'b0;
            m_eaddr = '0;
        end else if (!running) begin
            m_init_left--;
        end else begin
            if (bad && !m_err) begin
                m_err   = 1'b1;
                m_eaddr = a;
            end
            if (we && !bad) begin
                ix = (a / 4) % DEPTH;
                ln = a % 4;
                if (wb) begin
                    msk = 32'hFF << (ln * 8);
                    m_mem[ix] = (m_mem[ix] & ~msk) | ((wd % 256) << (ln * 8));
                end else begin
                    m_mem[ix] = wd;
                end
            end
        end
    endtask

    task automatic idle(input int n, input string nm);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, nm, 1'b0, 32'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                n_total++;
                if (ready !== e.rdy) begin
                    n_bad++;
                    $display("FAIL %s ready got=%0b want=%0b t=%0t", e.name, ready, e.rdy, $time);
                end
                n_total++;
                if (readdata !== e.rd) begin
                    n_bad++;
                    $display("FAIL %s readdata got=%08h want=%08h t=%0t", e.name, readdata, e.rd, $time);
                end
`ifdef DMEM_BOUNDS_CHECK_EN
                n_total++;
                if (err !== e.err || err_addr !== e.eaddr) begin
                    n_bad++;
                    $display("FAIL %s err got=%0b/%08h want=%0b/%08h t=%0t",
                             e.name, err, err_addr, e.err, e.eaddr, $time);
                end
`endif
            end
        end
    end

    initial begin
        logic [31:0] ra, rd;
        bit          rw, rb;

        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "reset", 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "reset", 1'b1, 32'h0);
        for (int i = 0; i < int'(DEPTH); i++)
            cyc(1'b0, 1'b0, 32'h3FC, 32'h0, 1'b0, "init", 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 32'h3FC, 32'h0, 1'b0, "init_rd", 1'b1, 32'h0);

        cyc(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "st_same_cycle", 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, "ld_word", 1'b1, 32'hDEADBEEF);

        cyc(1'b0, 1'b1, 32'h20, 32'h11223344, 1'b0, "st_word20", 1'b1, 32'h0);
        cyc(1'b0, 1'b1, 32'h22, 32'h000000AA, 1'b1, "st_byte22", 1'b1, 32'h22);
        cyc(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, "ld_merged", 1'b1, 32'h11AA3344);
        cyc(1'b0, 1'b0, 32'h22, 32'h0, 1'b1, "lb_neg", 1'b1, 32'hFFFFFFAA);
        cyc(1'b0, 1'b0, 32'h21, 32'h0, 1'b1, "lb_pos", 1'b1, 32'h00000033);

`ifdef DMEM_BOUNDS_CHECK_EN
        cyc(1'b0, 1'b1, 32'h402, 32'h77, 1'b0, "bad_store", 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, "word0_kept", 1'b1, 32'h0);
        cyc(1'b0, 1'b1, 32'h800, 32'h99, 1'b0, "bad_second", 1'b1, 32'h0);
        idle(2, "err_hold");
`else
        cyc(1'b0, 1'b1, 32'h400, 32'h5, 1'b0, "wrap_st", 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, "wrap_ld", 1'b1, 32'h5);
`endif

        cyc(1'b0, 1'b1, 32'h8, 32'h1234, 1'b0, "st_pre_reset", 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, "mid_run_reset", 1'b1, 32'h1234);
        idle(DEPTH, "reinit");
        cyc(1'b0, 1'b0, 32'h8, 32'h0, 1'b0, "cleared8", 1'b1, 32'h0);

        idle(5, "pre_rst2");
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "rst2", 1'b0, 32'h0);
        idle(40, "init_part");
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, "mid_init_reset", 1'b1, 32'h0);
        idle(DEPTH, "reinit2");

        for (int i = 0; i < 1500; i++) begin
            rw = ($urandom_range(0, 2) == 0);
            rb = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) ra = $urandom();
            else if (!rb && $urandom_range(0, 5) != 0) ra = $urandom_range(0, 255) * 4;
            else ra = $urandom_range(0, 1023);
            rd = $urandom();
            cyc(1'b0, rw, ra, rd, rb, "random", 1'b0, 32'h0);
        end

        idle(1, "tail");
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL drain pending got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
